// File: rtl/register_bank.sv
// Fifteen-entry register bank fed by one-hot write enables, with three
// combinational read ports, same-cycle write bypass, and R15 returning pc + PC_OFFSET.
module register_bank #(
  parameter int          WIDTH     = 32,
  parameter int unsigned PC_OFFSET = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en0,
  input  logic             en1,
  input  logic             en2,
  input  logic             en3,
  input  logic             en4,
  input  logic             en5,
  input  logic             en6,
  input  logic             en7,
  input  logic             en8,
  input  logic             en9,
  input  logic             en10,
  input  logic             en11,
  input  logic             en12,
  input  logic             en13,
  input  logic             en14,
  input  logic [WIDTH-1:0] writeData,
  input  logic [WIDTH-1:0] pc,
  input  logic [3:0]       ra1,
  input  logic [3:0]       ra2,
  input  logic [3:0]       ra3,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] rd3,
  output logic             multiWriteErr
);

  logic [14:0]      en;
  logic [WIDTH-1:0] wd_pipe;
  logic [WIDTH-1:0] regs [15];
  logic [WIDTH-1:0] pc_plus;
  logic             multi_hit;
  logic [3:0]       ra [3];
  logic [WIDTH-1:0] rd [3];

  assign en = {en14, en13, en12, en11, en10, en9, en8, en7,
               en6, en5, en4, en3, en2, en1, en0};

  // Clearing the lowest set bit leaves a nonzero value only when two or more enables are high.
  assign multi_hit = |(en & (en - 15'd1));
  assign pc_plus   = pc + WIDTH'(PC_OFFSET);

  // The write-data stage matches the decoder's registered enable latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_pipe <= '0;
    end else begin
      wd_pipe <= writeData;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 15; k++) regs[k] <= '0;
    end else begin
      for (int k = 0; k < 15; k++) begin
        if (en[k]) regs[k] <= wd_pipe;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      multiWriteErr <= 1'b0;
    end else if (multi_hit) begin
      multiWriteErr <= 1'b1;
    end
  end

  assign ra[0] = ra1;
  assign ra[1] = ra2;
  assign ra[2] = ra3;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd[p] = '0;
      if (ra[p] == 4'd15) begin
        rd[p] = pc_plus;
      end else if (en[ra[p]]) begin
        rd[p] = wd_pipe;
      end else begin
        rd[p] = regs[ra[p]];
      end
    end
  end

  assign rd1 = rd[0];
  assign rd2 = rd[1];
  assign rd3 = rd[2];

endmodule

// File: tb/tb_register_bank.sv
// Randomized plus directed bench for register_bank against an array-based
// reference model of the register file and its write-data stage.
module tb_register_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] en;
  logic [31:0] writeData;
  logic [31:0] pc;
  logic [3:0]  ra1, ra2, ra3;
  logic [31:0] rd1, rd2, rd3;
  logic        multiWriteErr;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg [15];
  logic [31:0] m_pipe;
  logic        m_err;

  register_bank #(.WIDTH(32), .PC_OFFSET(8)) dut (
    .clk(clk), .rst(rst),
    .en0(en[0]), .en1(en[1]), .en2(en[2]), .en3(en[3]), .en4(en[4]),
    .en5(en[5]), .en6(en[6]), .en7(en[7]), .en8(en[8]), .en9(en[9]),
    .en10(en[10]), .en11(en[11]), .en12(en[12]), .en13(en[13]), .en14(en[14]),
    .writeData(writeData), .pc(pc),
    .ra1(ra1), .ra2(ra2), .ra3(ra3),
    .rd1(rd1), .rd2(rd2), .rd3(rd3),
    .multiWriteErr(multiWriteErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [3:0] a);
    if (a == 4'd15) return pc + 32'd8;
    if (en[a]) return m_pipe;
    return m_reg[a];
  endfunction

  task automatic check_reads();
    chk("rd1", rd1, exp_rd(ra1));
    chk("rd2", rd2, exp_rd(ra2));
    chk("rd3", rd3, exp_rd(ra3));
    chk("multiWriteErr", {31'd0, multiWriteErr}, {31'd0, m_err});
  endtask

  // Advance one clock edge, apply the next cycle's inputs, then check.
  task automatic step(input logic [14:0] e, input logic [31:0] wd,
                      input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                      input logic [31:0] p);
    int cnt;
    @(posedge clk);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (en[k]) begin
        m_reg[k] = m_pipe;
        cnt++;
      end
    end
    if (cnt > 1) m_err = 1'b1;
    m_pipe = writeData;
    #1;
    en = e; writeData = wd; ra1 = a1; ra2 = a2; ra3 = a3; pc = p;
    #1;
    check_reads();
  endtask

  // Mid-cycle reset pulse; enables are left as they are.
  task automatic pulse_rst(input logic [3:0] a1, input logic [3:0] a2,
                           input logic [3:0] a3, input logic [31:0] p);
    #1;
    rst = 1'b1; ra1 = a1; ra2 = a2; ra3 = a3; pc = p;
    #1;
    for (int k = 0; k < 15; k++) m_reg[k] = 32'd0;
    m_pipe = 32'd0;
    m_err  = 1'b0;
    check_reads();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [14:0] e;
    rst = 1'b1; en = '0; writeData = '0; pc = '0; ra1 = '0; ra2 = '0; ra3 = '0;
    for (int k = 0; k < 15; k++) m_reg[k] = 32'd0;
    m_pipe = 32'd0;
    m_err  = 1'b0;
    #3 rst = 1'b0;

    // write timing
    step(15'd0, 32'hDEADBEEF, 4'd0, 4'd1, 4'd2, 32'd0);
    step(15'd1 << 5, 32'h12345678, 4'd5, 4'd15, 4'd3, 32'd0);
    chk("wt_bypass", rd1, 32'hDEADBEEF);
    step(15'd0, 32'd0, 4'd5, 4'd0, 4'd1, 32'd0);
    chk("wt_array", rd1, 32'hDEADBEEF);

    // back-to-back writes
    step(15'd0, 32'h11, 4'd2, 4'd7, 4'd5, 32'd0);
    step(15'd1 << 2, 32'h22, 4'd2, 4'd7, 4'd5, 32'd0);
    step(15'd1 << 7, 32'h0, 4'd2, 4'd7, 4'd5, 32'd0);
    step(15'd0, 32'h0, 4'd2, 4'd7, 4'd5, 32'd0);
    chk("b2b_r2", rd1, 32'h11);
    chk("b2b_r7", rd2, 32'h22);

    // reset values after R3 holds data
    step(15'd0, 32'hCAFE0003, 4'd3, 4'd3, 4'd3, 32'd0);
    step(15'd1 << 3, 32'd0, 4'd3, 4'd3, 4'd3, 32'd0);
    step(15'd0, 32'd0, 4'd3, 4'd3, 4'd3, 32'd0);
    chk("r3_written", rd1, 32'hCAFE0003);
    pulse_rst(4'd3, 4'd15, 4'd0, 32'h100);
    chk("rst_rd1", rd1, 32'h0);
    chk("rst_rd2", rd2, 32'h108);
    chk("rst_err", {31'd0, multiWriteErr}, 32'd0);

    // pc wrap
    step(15'd0, 32'd0, 4'd0, 4'd1, 4'd15, 32'hFFFFFFFC);
    chk("pc_wrap", rd3, 32'h4);

    // random single-enable traffic
    for (int i = 0; i < 300; i++) begin
      e = ($urandom_range(0, 3) == 0) ? 15'd0 : (15'd1 << $urandom_range(0, 14));
      step(e, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), $urandom);
    end
    chk("err_clean", {31'd0, multiWriteErr}, 32'd0);

    // multiple enables
    step(15'd0, 32'h55, 4'd0, 4'd14, 4'd15, 32'd0);
    step((15'd1 << 0) | (15'd1 << 14), 32'h0, 4'd0, 4'd14, 4'd15, 32'd0);
    chk("multi_err_pre", {31'd0, multiWriteErr}, 32'd0);
    step(15'd0, 32'h1, 4'd0, 4'd14, 4'd15, 32'd0);
    chk("multi_r0", rd1, 32'h55);
    chk("multi_r14", rd2, 32'h55);
    chk("multi_err_set", {31'd0, multiWriteErr}, 32'd1);
    step(15'd1 << 3, 32'h0, 4'd3, 4'd0, 4'd14, 32'd0);
    step(15'd0, 32'h0, 4'd3, 4'd0, 4'd14, 32'd0);
    chk("multi_err_sticky", {31'd0, multiWriteErr}, 32'd1);

    // random traffic with occasional multi-enable
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 7))
        0:       e = 15'd0;
        1:       e = 15'($urandom);
        default: e = 15'd1 << $urandom_range(0, 14);
      endcase
      step(e, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), $urandom);
    end

    // reset mid-write drops the pending R9 write
    step(15'd0, 32'hAA, 4'd9, 4'd15, 4'd0, 32'd0);
    step(15'd1 << 9, 32'h0, 4'd9, 4'd15, 4'd0, 32'd0);
    chk("mw_bypass", rd1, 32'hAA);
    pulse_rst(4'd9, 4'd15, 4'd0, 32'd0);
    chk("mw_err_clear", {31'd0, multiWriteErr}, 32'd0);
    step(15'd0, 32'h0, 4'd9, 4'd15, 4'd0, 32'd0);
    chk("mw_r9", rd1, 32'h0);
    for (int k = 0; k < 15; k++) begin
      step(15'd0, 32'h0, 4'(k), 4'd15, 4'd15, 32'd0);
      chk("post_rst_zero", rd1, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
